// File: rtl/store_buffer_fwd.sv
// ---------------------------------------------------------------------------
// store_buffer_fwd
//
// Two-stage store buffer that sits between the LSU store unit and the D$ write
// port. Stores enter a speculative FIFO. On commit they move to a commit FIFO.
// The commit FIFO drains to memory, one entry per grant. Each load query is
// checked in the same cycle against every buffered store. The result is one of
// three outcomes:
//   - stall,
//   - full forward from the youngest covering store,
//   - no conflict.
//
// Optional feature macro: STORE_BUFFER_FWD_EN
//   defined   : store-to-load forwarding is enabled
//   undefined : ld_fwd_hit_o/ld_fwd_data_o are held at 0, and every conflict
//               stalls the load
//
// Ports
//   clk_i, rst_i              clock, synchronous active-high reset
//   flush_i                   discard all speculative entries
//   valid_i                   push a store (paddr_i/data_i/be_i/data_size_i)
//   valid_without_flush_i     paddr_i is live; used for the conflict check only
//   ready_o                   speculative FIFO can accept a push
//   commit_i                  move the oldest speculative entry to the commit FIFO
//   commit_ready_o            commit FIFO has space (registered count only)
//   no_st_pending_o           commit FIFO empty
//   store_buffer_empty_o      both FIFOs empty
//   ld_valid_i/ld_paddr_i/ld_be_i   load query
//   ld_stall_o/ld_fwd_hit_o/ld_fwd_data_o   load check result
//   mem_req_o/mem_gnt_i/mem_addr_o/mem_wdata_o/mem_be_o/mem_size_o
//                             write port, driven from the commit FIFO head
// ---------------------------------------------------------------------------
module store_buffer_fwd #(
    parameter int unsigned PLEN         = 34,
    parameter int unsigned XLEN         = 64,
    parameter int unsigned DEPTH_SPEC   = 4,
    parameter int unsigned DEPTH_COMMIT = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                valid_i,
    input  logic                valid_without_flush_i,
    input  logic [PLEN-1:0]     paddr_i,
    input  logic [XLEN-1:0]     data_i,
    input  logic [XLEN/8-1:0]   be_i,
    input  logic [1:0]          data_size_i,
    output logic                ready_o,
    input  logic                commit_i,
    output logic                commit_ready_o,
    output logic                no_st_pending_o,
    output logic                store_buffer_empty_o,
    input  logic                ld_valid_i,
    input  logic [PLEN-1:0]     ld_paddr_i,
    input  logic [XLEN/8-1:0]   ld_be_i,
    output logic                ld_stall_o,
    output logic                ld_fwd_hit_o,
    output logic [XLEN-1:0]     ld_fwd_data_o,
    output logic                mem_req_o,
    input  logic                mem_gnt_i,
    output logic [PLEN-1:0]     mem_addr_o,
    output logic [XLEN-1:0]     mem_wdata_o,
    output logic [XLEN/8-1:0]   mem_be_o,
    output logic [1:0]          mem_size_o
);

    localparam int unsigned BEW = XLEN / 8;
    localparam int unsigned W   = $clog2(BEW);
    localparam int unsigned SPW = $clog2(DEPTH_SPEC);
    localparam int unsigned CMW = $clog2(DEPTH_COMMIT);

    typedef struct packed {
        logic [PLEN-1:0] addr;
        logic [XLEN-1:0] data;
        logic [BEW-1:0]  be;
        logic [1:0]      size;
        logic            valid;
    } entry_t;

    entry_t         spec_q   [DEPTH_SPEC];
    entry_t         commit_q [DEPTH_COMMIT];

    logic [SPW-1:0] spec_wr, spec_rd;
    logic [SPW:0]   spec_cnt;
    logic [CMW-1:0] commit_wr, commit_rd;
    logic [CMW:0]   commit_cnt;

    logic           mem_fire;
    logic           commit_do;
    entry_t         head;

    assign head      = commit_q[commit_rd];
    assign mem_fire  = mem_req_o & mem_gnt_i;
    // A flush always wins; a simultaneous commit is dropped.
    assign commit_do = commit_i & ~flush_i;

    assign ready_o              = spec_cnt < (SPW + 1)'(DEPTH_SPEC);
    assign commit_ready_o       = commit_cnt < (CMW + 1)'(DEPTH_COMMIT);
    assign no_st_pending_o      = commit_cnt == '0;
    assign store_buffer_empty_o = (spec_cnt == '0) && (commit_cnt == '0);

    assign mem_req_o   = head.valid;
    assign mem_addr_o  = head.addr;
    assign mem_wdata_o = head.data;
    assign mem_be_o    = head.be;
    assign mem_size_o  = head.size;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            spec_wr    <= '0;
            spec_rd    <= '0;
            spec_cnt   <= '0;
            commit_wr  <= '0;
            commit_rd  <= '0;
            commit_cnt <= '0;
            for (int i = 0; i < DEPTH_SPEC; i++)   spec_q[i].valid   <= 1'b0;
            for (int i = 0; i < DEPTH_COMMIT; i++) commit_q[i].valid <= 1'b0;
        end else begin
            // The retire and the commit write can only alias when the
            // commit FIFO is empty. In that case mem_fire is 0, so the
            // order of the two writes does not matter.
            if (mem_fire) begin
                commit_q[commit_rd].valid <= 1'b0;
                commit_rd                 <= commit_rd + CMW'(1);
            end

            if (flush_i) begin
                for (int i = 0; i < DEPTH_SPEC; i++) spec_q[i].valid <= 1'b0;
                spec_wr  <= spec_rd;
                spec_cnt <= '0;
            end else begin
                if (commit_i) begin
                    commit_q[commit_wr]   <= spec_q[spec_rd];
                    spec_q[spec_rd].valid <= 1'b0;
                    spec_rd               <= spec_rd + SPW'(1);
                    commit_wr             <= commit_wr + CMW'(1);
                end
                if (valid_i) begin
                    spec_q[spec_wr] <= '{addr: paddr_i, data: data_i, be: be_i,
                                         size: data_size_i, valid: 1'b1};
                    spec_wr         <= spec_wr + SPW'(1);
                end
                spec_cnt <= spec_cnt + {{SPW{1'b0}}, valid_i} - {{SPW{1'b0}}, commit_i};
            end

            commit_cnt <= commit_cnt + {{CMW{1'b0}}, commit_do} - {{CMW{1'b0}}, mem_fire};
        end
    end

    // Youngest-first search. Valid entries sit between rd and wr-1 in each
    // FIFO, so walking backwards from wr-1 visits them in age order. The
    // first page-offset match found is the youngest conflict.
    logic   conflict;
    entry_t cand;

    always_comb begin
        conflict = 1'b0;
        cand     = '0;
        for (int k = 0; k < DEPTH_SPEC; k++) begin
            if (!conflict && spec_q[spec_wr - SPW'(k + 1)].valid &&
                spec_q[spec_wr - SPW'(k + 1)].addr[11:W] == ld_paddr_i[11:W]) begin
                conflict = 1'b1;
                cand     = spec_q[spec_wr - SPW'(k + 1)];
            end
        end
        for (int k = 0; k < DEPTH_COMMIT; k++) begin
            if (!conflict && commit_q[commit_wr - CMW'(k + 1)].valid &&
                commit_q[commit_wr - CMW'(k + 1)].addr[11:W] == ld_paddr_i[11:W]) begin
                conflict = 1'b1;
                cand     = commit_q[commit_wr - CMW'(k + 1)];
            end
        end
    end

    // A store whose address is on paddr_i this cycle has not been buffered
    // yet. It cannot forward, so it always stalls an overlapping load.
    logic live_conflict;
    assign live_conflict = valid_without_flush_i && (paddr_i[11:W] == ld_paddr_i[11:W]);

`ifdef STORE_BUFFER_FWD_EN
    logic covers;
    assign covers = (cand.addr[PLEN-1:W] == ld_paddr_i[PLEN-1:W]) &&
                    ((cand.be & ld_be_i) == ld_be_i);

    always_comb begin
        ld_stall_o    = 1'b0;
        ld_fwd_hit_o  = 1'b0;
        ld_fwd_data_o = '0;
        if (ld_valid_i) begin
            if (live_conflict) begin
                ld_stall_o = 1'b1;
            end else if (conflict) begin
                if (covers) begin
                    ld_fwd_hit_o  = 1'b1;
                    ld_fwd_data_o = cand.data;
                end else begin
                    ld_stall_o = 1'b1;
                end
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{cand.size, cand.valid, ld_paddr_i[W-1:0]};
`else
    always_comb begin
        ld_stall_o = ld_valid_i && (live_conflict || conflict);
    end
    assign ld_fwd_hit_o  = 1'b0;
    assign ld_fwd_data_o = '0;

    logic unused_bits;
    assign unused_bits = ^{cand, ld_be_i, ld_paddr_i[PLEN-1:12], ld_paddr_i[W-1:0]};
`endif

    // Protocol checks on the upstream interfaces.
    a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
        valid_i |-> ready_o);
    a_no_commit_empty: assert property (@(posedge clk_i) disable iff (rst_i)
        commit_i |-> (spec_cnt != '0));
    a_no_commit_full: assert property (@(posedge clk_i) disable iff (rst_i)
        commit_i |-> commit_ready_o);
    a_no_flush_commit: assert property (@(posedge clk_i) disable iff (rst_i)
        !(flush_i && commit_i));

endmodule

// File: tb/tb_store_buffer_fwd.sv
module tb_store_buffer_fwd;

    localparam int PLEN = 34;
    localparam int XLEN = 64;
    localparam int BEW  = 8;
    localparam int DS   = 4;
    localparam int DC   = 8;
`ifdef STORE_BUFFER_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic            rst_i, flush_i, valid_i, valid_without_flush_i, commit_i;
    logic [PLEN-1:0] paddr_i, ld_paddr_i;
    logic [XLEN-1:0] data_i;
    logic [BEW-1:0]  be_i, ld_be_i;
    logic [1:0]      data_size_i;
    logic            ready_o, commit_ready_o, no_st_pending_o, store_buffer_empty_o;
    logic            ld_valid_i, ld_stall_o, ld_fwd_hit_o;
    logic [XLEN-1:0] ld_fwd_data_o;
    logic            mem_req_o, mem_gnt_i;
    logic [PLEN-1:0] mem_addr_o;
    logic [XLEN-1:0] mem_wdata_o;
    logic [BEW-1:0]  mem_be_o;
    logic [1:0]      mem_size_o;

    store_buffer_fwd #(.PLEN(PLEN), .XLEN(XLEN), .DEPTH_SPEC(DS), .DEPTH_COMMIT(DC)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i),
        .valid_without_flush_i(valid_without_flush_i), .paddr_i(paddr_i),
        .data_i(data_i), .be_i(be_i), .data_size_i(data_size_i), .ready_o(ready_o),
        .commit_i(commit_i), .commit_ready_o(commit_ready_o),
        .no_st_pending_o(no_st_pending_o), .store_buffer_empty_o(store_buffer_empty_o),
        .ld_valid_i(ld_valid_i), .ld_paddr_i(ld_paddr_i), .ld_be_i(ld_be_i),
        .ld_stall_o(ld_stall_o), .ld_fwd_hit_o(ld_fwd_hit_o), .ld_fwd_data_o(ld_fwd_data_o),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_size_o(mem_size_o)
    );

    typedef struct {
        logic            rst, flush, valid, vwf, commit, ld_valid, gnt;
        logic [PLEN-1:0] paddr, ld_paddr;
        logic [XLEN-1:0] data;
        logic [BEW-1:0]  be, ld_be;
        logic [1:0]      size;
    } stim_t;

    typedef struct {
        logic [PLEN-1:0] a;
        logic [XLEN-1:0] d;
        logic [BEW-1:0]  be;
        logic [1:0]      sz;
    } ment_t;

    typedef struct {
        stim_t           s;
        logic            stall, hit, req;
        logic [XLEN-1:0] data;
    } vec_t;

    // Reference model: plain ordered lists, oldest at index 0.
    ment_t spec_m[$];
    ment_t com_m[$];
    stim_t cur;
    int    n_chk  = 0;
    int    n_fail = 0;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    function automatic stim_t push_s(input logic [PLEN-1:0] a, input logic [XLEN-1:0] d,
                                     input logic [BEW-1:0] be, input logic [1:0] sz);
        stim_t s;
        s = idle();
        s.valid = 1'b1; s.paddr = a; s.data = d; s.be = be; s.size = sz;
        return s;
    endfunction

    function automatic stim_t ld_s(input logic [PLEN-1:0] a, input logic [BEW-1:0] be);
        stim_t s;
        s = idle();
        s.ld_valid = 1'b1; s.ld_paddr = a; s.ld_be = be;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        cur                   = s;
        rst_i                 = s.rst;
        flush_i               = s.flush;
        valid_i               = s.valid;
        valid_without_flush_i = s.vwf;
        paddr_i               = s.paddr;
        data_i                = s.data;
        be_i                  = s.be;
        data_size_i           = s.size;
        commit_i              = s.commit;
        ld_valid_i            = s.ld_valid;
        ld_paddr_i            = s.ld_paddr;
        ld_be_i               = s.ld_be;
        mem_gnt_i             = s.gnt;
    endtask

    task automatic model_load(output logic stall, output logic hit, output logic [XLEN-1:0] data);
        ment_t e;
        bit    found;
        stall = 1'b0; hit = 1'b0; data = '0; found = 1'b0;
        e = '{default: '0};
        if (cur.ld_valid) begin
            if (cur.vwf && cur.paddr[11:3] == cur.ld_paddr[11:3]) begin
                stall = 1'b1;
            end else begin
                for (int i = spec_m.size() - 1; i >= 0 && !found; i--)
                    if (spec_m[i].a[11:3] == cur.ld_paddr[11:3]) begin e = spec_m[i]; found = 1'b1; end
                for (int i = com_m.size() - 1; i >= 0 && !found; i--)
                    if (com_m[i].a[11:3] == cur.ld_paddr[11:3]) begin e = com_m[i]; found = 1'b1; end
                if (found) begin
                    if (FWD && e.a[PLEN-1:3] == cur.ld_paddr[PLEN-1:3] &&
                        (e.be & cur.ld_be) == cur.ld_be) begin
                        hit = 1'b1; data = e.d;
                    end else begin
                        stall = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic model_check();
        logic            st, ht;
        logic [XLEN-1:0] dt;
        chk("ready_o", ready_o, spec_m.size() < DS);
        chk("commit_ready_o", commit_ready_o, com_m.size() < DC);
        chk("no_st_pending_o", no_st_pending_o, com_m.size() == 0);
        chk("store_buffer_empty_o", store_buffer_empty_o, spec_m.size() == 0 && com_m.size() == 0);
        chk("mem_req_o", mem_req_o, com_m.size() > 0);
        if (com_m.size() > 0) begin
            chk("mem_addr_o", mem_addr_o, com_m[0].a);
            chk("mem_wdata_o", mem_wdata_o, com_m[0].d);
            chk("mem_be_o", mem_be_o, com_m[0].be);
            chk("mem_size_o", mem_size_o, com_m[0].sz);
        end
        model_load(st, ht, dt);
        chk("ld_stall_o", ld_stall_o, st);
        chk("ld_fwd_hit_o", ld_fwd_hit_o, ht);
        chk("ld_fwd_data_o", ld_fwd_data_o, dt);
    endtask

    task automatic apply(input stim_t s);
        drive(s);
        #1;
        model_check();
    endtask

    task automatic edge_tick();
        ment_t e;
        bit    fire;
        @(posedge clk_i);
        if (cur.rst) begin
            spec_m.delete();
            com_m.delete();
        end else begin
            fire = (com_m.size() > 0) && cur.gnt;
            if (cur.flush) begin
                spec_m.delete();
            end else begin
                if (cur.commit) begin
                    e = spec_m.pop_front();
                    com_m.push_back(e);
                end
                if (cur.valid) spec_m.push_back('{cur.paddr, cur.data, cur.be, cur.size});
            end
            if (fire) void'(com_m.pop_front());
        end
        #1;
    endtask

    task automatic cyc(input stim_t s);
        apply(s);
        edge_tick();
    endtask

    function automatic logic [PLEN-1:0] rnd_addr();
        logic [PLEN-1:0] pg, off;
        case ($urandom_range(0, 2))
            0: pg = 34'h1000;
            1: pg = 34'h2000;
            default: pg = 34'h5000;
        endcase
        off = PLEN'(8 * $urandom_range(0, 2));
        return pg + off + PLEN'($urandom_range(0, 7));
    endfunction

    localparam logic [XLEN-1:0] D1 = 64'hD1D1_D1D1_D1D1_D1D1;
    localparam logic [XLEN-1:0] D2 = 64'hD2D2_0000_D2D2_0002;
    localparam logic [XLEN-1:0] D3 = 64'h3333_5008_3333_5008;

    vec_t  vec[14];
    stim_t s;

    function automatic vec_t mk(input stim_t st, input logic stall, input logic hit,
                                input logic [XLEN-1:0] data, input logic req);
        vec_t v;
        v.s = st; v.stall = stall; v.hit = hit; v.data = data; v.req = req;
        return v;
    endfunction

    initial begin
        // Forwarding / page-match sequence with hand-derived expectations.
        vec[0]  = mk(push_s(34'h2000, D1, 8'hFF, 2'd3), 0, 0, '0, 0);
        vec[1]  = mk(push_s(34'h2000, D2, 8'h0F, 2'd2), 0, 0, '0, 0);
        vec[2]  = mk(ld_s(34'h2000, 8'h0F), !FWD, FWD, FWD ? D2 : '0, 0);
        vec[3]  = mk(ld_s(34'h2000, 8'hF0), 1, 0, '0, 0);
        vec[4]  = mk(ld_s(34'h2004, 8'h0F), !FWD, FWD, FWD ? D2 : '0, 0);
        s = ld_s(34'h2000, 8'h0F); s.vwf = 1'b1; s.paddr = 34'h7000;
        vec[5]  = mk(s, 1, 0, '0, 0);
        s = idle(); s.flush = 1'b1;
        vec[6]  = mk(s, 0, 0, '0, 0);
        vec[7]  = mk(ld_s(34'h2000, 8'h0F), 0, 0, '0, 0);
        vec[8]  = mk(push_s(34'h5008, D3, 8'hFF, 2'd3), 0, 0, '0, 0);
        s = idle(); s.commit = 1'b1;
        vec[9]  = mk(s, 0, 0, '0, 0);
        vec[10] = mk(ld_s(34'h3008, 8'hFF), 1, 0, '0, 1);
        vec[11] = mk(ld_s(34'h5008, 8'hFF), !FWD, FWD, FWD ? D3 : '0, 1);
        s = ld_s(34'h5008, 8'hFF); s.gnt = 1'b1;
        vec[12] = mk(s, !FWD, FWD, FWD ? D3 : '0, 1);
        vec[13] = mk(ld_s(34'h3008, 8'hFF), 0, 0, '0, 0);

        // Reset
        s = ld_s(34'h1000, 8'hFF); s.rst = 1'b1;
        drive(s);
        edge_tick();
        apply(s);
        chk("rst ready_o", ready_o, 1'b1);
        chk("rst commit_ready_o", commit_ready_o, 1'b1);
        chk("rst no_st_pending_o", no_st_pending_o, 1'b1);
        chk("rst store_buffer_empty_o", store_buffer_empty_o, 1'b1);
        chk("rst mem_req_o", mem_req_o, 1'b0);
        chk("rst ld_stall_o", ld_stall_o, 1'b0);
        chk("rst ld_fwd_hit_o", ld_fwd_hit_o, 1'b0);
        edge_tick();

        // Fill the speculative FIFO
        for (int i = 0; i < 4; i++)
            cyc(push_s(PLEN'(34'h1000 + 8 * i), 64'(i + 1), 8'hFF, 2'd3));
        apply(idle());
        chk("full ready_o", ready_o, 1'b0);
        chk("full store_buffer_empty_o", store_buffer_empty_o, 1'b0);
        edge_tick();
        s = idle(); s.flush = 1'b1;
        cyc(s);
        apply(idle());
        chk("post-flush ready_o", ready_o, 1'b1);
        chk("post-flush empty", store_buffer_empty_o, 1'b1);
        edge_tick();

        // Held request
        cyc(push_s(34'h1000, 64'h1111_1111_1111_1111, 8'hFF, 2'd3));
        s = idle(); s.commit = 1'b1;
        cyc(s);
        for (int i = 0; i < 3; i++) begin
            apply(idle());
            chk("held mem_req_o", mem_req_o, 1'b1);
            chk("held mem_addr_o", mem_addr_o, 34'h1000);
            edge_tick();
        end
        s = idle(); s.gnt = 1'b1;
        cyc(s);
        apply(idle());
        chk("after gnt no_st_pending_o", no_st_pending_o, 1'b1);
        edge_tick();

        // Table-driven forwarding sequence
        for (int i = 0; i < 14; i++) begin
            apply(vec[i].s);
            chk($sformatf("vec%0d ld_stall_o", i), ld_stall_o, vec[i].stall);
            chk($sformatf("vec%0d ld_fwd_hit_o", i), ld_fwd_hit_o, vec[i].hit);
            chk($sformatf("vec%0d ld_fwd_data_o", i), ld_fwd_data_o, vec[i].data);
            chk($sformatf("vec%0d mem_req_o", i), mem_req_o, vec[i].req);
            edge_tick();
        end

        // Commit FIFO full with a grant arriving
        cyc(push_s(34'h6000, 64'h600, 8'hFF, 2'd3));
        for (int i = 1; i < 8; i++) begin
            s = push_s(PLEN'(34'h6000 + 8 * i), 64'(16'h600 + i), 8'hFF, 2'd3);
            s.commit = 1'b1;
            cyc(s);
        end
        s = idle(); s.commit = 1'b1;
        cyc(s);
        apply(idle());
        chk("cfull commit_ready_o", commit_ready_o, 1'b0);
        edge_tick();
        s = idle(); s.gnt = 1'b1;
        apply(s);
        chk("cfull gnt-cycle commit_ready_o", commit_ready_o, 1'b0);
        edge_tick();
        apply(idle());
        chk("cfull next commit_ready_o", commit_ready_o, 1'b1);
        edge_tick();
        for (int i = 0; i < 7; i++) cyc(s);
        apply(idle());
        chk("drained no_st_pending_o", no_st_pending_o, 1'b1);
        edge_tick();

        // Pointer wrap over 20 pushes, then flush of three wrapped entries
        for (int i = 0; i < 20; i++) begin
            s = push_s(PLEN'(34'h8000 + 8 * i), {$urandom, $urandom}, 8'(i + 1), 2'(i));
            s.commit = spec_m.size() > 0;
            s.gnt = 1'b1;
            cyc(s);
        end
        s = idle(); s.commit = 1'b1; s.gnt = 1'b1;
        cyc(s);
        s.commit = 1'b0;
        for (int i = 0; i < 3; i++) cyc(s);
        for (int i = 0; i < 3; i++) cyc(push_s(PLEN'(34'h4000 + 8 * i), 64'(i + 64'hA0), 8'hFF, 2'd3));
        apply(ld_s(34'h4008, 8'hFF));
        chk("wrap3 ld_stall_o", ld_stall_o, !FWD);
        edge_tick();
        s = idle(); s.flush = 1'b1;
        cyc(s);
        for (int i = 0; i < 3; i++) begin
            apply(ld_s(PLEN'(34'h4000 + 8 * i), 8'hFF));
            chk("wrap flush ready_o", ready_o, 1'b1);
            chk("wrap flush empty", store_buffer_empty_o, 1'b1);
            chk("wrap flush ld_stall_o", ld_stall_o, 1'b0);
            chk("wrap flush ld_fwd_hit_o", ld_fwd_hit_o, 1'b0);
            edge_tick();
        end

        // Reset mid-operation with an ungranted request
        cyc(push_s(34'h9000, 64'h9, 8'hFF, 2'd3));
        s = idle(); s.commit = 1'b1;
        cyc(s);
        apply(idle());
        chk("pre-rst mem_req_o", mem_req_o, 1'b1);
        edge_tick();
        s = idle(); s.rst = 1'b1;
        cyc(s);
        apply(idle());
        chk("mid-rst mem_req_o", mem_req_o, 1'b0);
        chk("mid-rst no_st_pending_o", no_st_pending_o, 1'b1);
        chk("mid-rst empty", store_buffer_empty_o, 1'b1);
        edge_tick();

        // Random traffic against the reference model
        for (int n = 0; n < 600; n++) begin
            s = idle();
            s.rst      = ($urandom_range(0, 199) == 0);
            s.flush    = ($urandom_range(0, 19) == 0);
            s.valid    = (spec_m.size() < DS) && ($urandom_range(0, 1) == 1);
            s.commit   = !s.flush && (spec_m.size() > 0) && (com_m.size() < DC) &&
                         ($urandom_range(0, 2) != 0);
            s.gnt      = ($urandom_range(0, 1) == 1);
            s.vwf      = ($urandom_range(0, 3) == 0);
            s.paddr    = rnd_addr();
            s.data     = {$urandom, $urandom};
            s.be       = 8'($urandom_range(1, 255));
            s.size     = 2'($urandom_range(0, 3));
            s.ld_valid = ($urandom_range(0, 3) != 0);
            s.ld_paddr = rnd_addr();
            s.ld_be    = 8'($urandom_range(1, 255));
            cyc(s);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/store_buffer_fwd.md
# store_buffer_fwd

Parametrised two-stage store buffer between the LSU store unit and the D$ write port, with store-to-load forwarding. Stores enter a speculative FIFO and move to a commit FIFO on commit. The commit FIFO drains to memory one entry per grant. Loads are checked against every buffered store in the same cycle. The result is a stall, a full forward from the youngest fully covering store, or no conflict.

## Interface
- PLEN, 34: physical address width.
- XLEN, 64: data width; BE width is XLEN/8; word-offset bits are log2(XLEN/8).
- DEPTH_SPEC, 4: speculative FIFO entries, power of two, ≥2.
- DEPTH_COMMIT, 8: commit FIFO entries, power of two, ≥2.
- clk_i  in  1  clock.
- rst_i  in  1  **synchronous, active-high reset; one clock domain (clk_i).**
- flush_i  in  1  discard all speculative entries.
- valid_i  in  1  push store.
- valid_without_flush_i  in  1  store address on paddr_i is live (conflict check only).
- paddr_i  in  PLEN  store address.
- data_i  in  XLEN  store data.
- be_i  in  XLEN/8  store byte enables.
- data_size_i  in  2  store size.
- ready_o  out  1  speculative FIFO can accept a push.
- commit_i  in  1  move the oldest speculative entry to the commit FIFO.
- commit_ready_o  out  1  commit FIFO has space.
- no_st_pending_o  out  1  commit FIFO empty.
- store_buffer_empty_o  out  1  both FIFOs empty.
- ld_valid_i  in  1  load query valid.
- ld_paddr_i  in  PLEN  load address.
- ld_be_i  in  XLEN/8  load byte enables.
- ld_stall_o  out  1  load must wait for the buffer to drain.
- ld_fwd_hit_o  out  1  load is satisfied by forwarded data.
- ld_fwd_data_o  out  XLEN  forwarded word.
- mem_req_o  out  1  write request.
- mem_gnt_i  in  1  write granted.
- mem_addr_o  out  PLEN  head address.
- mem_wdata_o  out  XLEN  head data.
- mem_be_o  out  XLEN/8  head byte enables.
- mem_size_o  out  2  head size.

## Operation
- Entry fields: address, data, be, size, valid. Each FIFO keeps read and write pointers of log2(depth) bits (natural wrap) and a count of log2(depth)+1 bits.
- ready_o = spec_cnt < DEPTH_SPEC.
- commit_ready_o = commit_cnt < DEPTH_COMMIT. It is based on the registered count only, with no same-cycle grant bypass.
- Push: on valid_i, write the entry at spec_wr and increment spec_wr.
- Commit: on commit_i, copy the spec_rd entry to commit_wr, clear its valid bit, and increment spec_rd and commit_wr.
- spec_cnt_n = spec_cnt + valid_i − commit_i. commit_cnt_n = commit_cnt + commit_i − (mem_req_o & mem_gnt_i).
- Flush: clear all speculative valid bits, set spec_wr to spec_rd, and set spec_cnt to 0. Flush overrides a push in the same cycle.
- flush_i together with commit_i is a protocol violation. An assertion flags it; the RTL lets flush win and drops the commit.
- Memory drain: mem_req_o = valid bit of the commit FIFO head. The mem_* fields are driven from the head. On mem_gnt_i, retire the head; rvalid is not tracked. The request stays asserted until granted.
- Load check, applied when ld_valid_i = 1:
  - An entry "matches" when its address[11:w] equals ld_paddr_i[11:w], where w is the word-offset bit count.
  - Search order is youngest speculative, then older speculative, then youngest commit, then oldest commit.
  - The first matching entry is the youngest conflict.
  - A forward hit requires the youngest conflict's full address[PLEN-1:w] to equal the load's and (entry.be & ld_be_i) == ld_be_i. Then ld_fwd_hit_o = 1, ld_fwd_data_o = entry.data, and ld_stall_o = 0.
  - Any other conflict gives ld_stall_o = 1.
  - If valid_without_flush_i = 1 and paddr_i[11:w] matches the load, the result is always a stall, never a forward.
- All outputs are 0 when ld_valid_i = 0.
- Assertions: no push when full; no commit when the speculative FIFO is empty; no commit when the commit FIFO is full.

## Timing
- Reset: all pointers, counts and valid bits are 0. Outputs: ready_o=1, commit_ready_o=1, no_st_pending_o=1, store_buffer_empty_o=1, mem_req_o=0, ld_*=0.
- Push to commit eligibility: 1 cycle. Commit to mem_req_o: 1 cycle. Back-to-back grants retire one entry per cycle.
- Load check and mem_* outputs are combinational from registered state and the current inputs.
- Reset asserted mid-operation discards all entries at the next edge, including an ungranted request.

## Configuration
- STORE_BUFFER_FWD_EN defined: forwarding is enabled as described above.
- STORE_BUFFER_FWD_EN undefined: ld_fwd_hit_o and ld_fwd_data_o are tied to 0, and every conflict stalls.

## Test plan
- Reset, then push 4 stores with commit_i low -> ready_o=0 and store_buffer_empty_o=0; a fifth valid_i fires the assertion.
- Push A=0x1000 (data 0x11…, be 0xFF), commit, hold mem_gnt_i low for 3 cycles -> mem_req_o stays 1 with mem_addr_o=0x1000; grant -> no_st_pending_o=1 on the next cycle.
- Push 0x2000 (be 0xFF, data D1), push 0x2000 (be 0x0F, data D2), then load 0x2000 with be 0x0F -> forward hit with D2. Load with be 0xF0 -> stall, because the youngest conflict does not cover the load.
- Load 0x3008 against a commit entry at 0x5008 -> stall (page offset match, different page). With the macro off, the 0x2000 case above also stalls.
- Commit FIFO full while a grant arrives -> commit_ready_o stays 0 that cycle and is 1 in the next.
- Three speculative entries with the pointer wrapped, then flush_i -> spec_cnt=0 and a load to those addresses has no conflict. Pointers keep wrapping correctly over 20 pushes.
